// File: rtl/hit_frame_pkg.sv
// Shared types for the self-triggered frame builder: magic bytes, FSM
// encoding, header/footer word layouts and the FIFO payload.
package hit_frame_pkg;

    localparam int unsigned WORD_W    = 64;
    localparam logic [7:0]  HDR_MAGIC = 8'hAA;
    localparam logic [7:0]  FTR_MAGIC = 8'h55;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BODY   = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FOOTER = 2'd3
    } state_e;

    // Footer flag nibble, MSB first: OVF, MAXLEN, PARTIAL, EMPTY
    typedef struct packed {
        logic ovf;
        logic maxlen;
        logic partial;
        logic empty;
    } ftr_flags_t;

    // Header word: magic[63:56] ch[55:48] timestamp[47:24] reserved[23:0]
    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  ch_id;
        logic [23:0] ts;
        logic [23:0] rsvd;
    } hdr_word_t;

    // Footer word: magic[63:56] ch[55:48] wcnt[47:32] flags[31:28] pad[27:25] reserved[24:0]
    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  ch_id;
        logic [15:0] wcnt;
        ftr_flags_t  flags;
        logic [2:0]  pad;
        logic [24:0] rsvd;
    } ftr_word_t;

    // FIFO entry: TLAST alongside the data word
    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } fifo_word_t;

    function automatic hdr_word_t make_header(input logic [7:0] ch, input logic [23:0] ts);
        hdr_word_t h;
        h.magic = HDR_MAGIC;
        h.ch_id = ch;
        h.ts    = ts;
        h.rsvd  = '0;
        return h;
    endfunction

    function automatic ftr_word_t make_footer(input logic [7:0] ch, input logic [15:0] wcnt,
                                              input ftr_flags_t flags, input logic [2:0] pad);
        ftr_word_t f;
        f.magic = FTR_MAGIC;
        f.ch_id = ch;
        f.wcnt  = wcnt;
        f.flags = flags;
        f.pad   = pad;
        f.rsvd  = '0;
        return f;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_word_fifo.sv
// First-word-fall-through FIFO for frame words; reports free entries so the
// producer can reserve room for the words that must follow.
module frame_word_fifo
    import hit_frame_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  fifo_word_t          wr_data,
    input  logic                rd_ready,
    output fifo_word_t          rd_data,
    output logic                rd_valid,
    output logic [DEPTH_LOG2:0] free
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    fifo_word_t            mem_q [DEPTH];
    fifo_word_t            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  not_empty;
    logic                  do_wr;
    logic                  do_rd;

    // Pointer/count update and storage write
    always_comb begin
        not_empty = (count_q != '0);
        do_wr     = wr_en && (count_q != CNT_W'(DEPTH));
        do_rd     = rd_ready && not_empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_d     = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Head word is masked to zero while empty so the output bus idles at zero
    always_comb begin
        rd_valid = not_empty;
        rd_data  = not_empty ? mem_q[rd_ptr_q] : '0;
        free     = CNT_W'(DEPTH) - count_q;
    end

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, contents qualified by count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/hit_frame_gen.sv
// Self-triggered frame builder: trigger compare on the undelayed stream,
// packing of the delayed stream into 64-bit words, header/body/footer framing
// onto an AXI-Stream master through an FWFT FIFO.
// Optional build macro HIT_FRAME_HYSTERESIS_EN adds the HYST input and ends a
// frame only once DIN falls below THRESHOLD-HYST (saturating).
// A trigger must be re-armed by a non-hit sample before another frame (or a
// drop) can be started, so a level held high yields a single frame.
module hit_frame_gen
    import hit_frame_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned TIMESTAMP_WIDTH = 24,
    parameter int unsigned MAX_LEN_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 5
) (
    input  logic                     CLK,
    input  logic                     RESETN,
`ifdef HIT_FRAME_HYSTERESIS_EN
    input  logic [SAMPLE_WIDTH-1:0]  HYST,
`endif
    input  logic [SAMPLE_WIDTH-1:0]  THRESHOLD,
    input  logic [7:0]               CH_ID,
    input  logic [MAX_LEN_WIDTH-1:0] MAX_LEN,
    input  logic [SAMPLE_WIDTH-1:0]  DIN,
    input  logic                     DIN_VALID,
    input  logic [SAMPLE_WIDTH-1:0]  DELAYED_DIN,
    input  logic                     DELAYED_VALID,
    output logic [63:0]              M_TDATA,
    output logic                     M_TVALID,
    input  logic                     M_TREADY,
    output logic                     M_TLAST,
    output logic [15:0]              DROP_CNT,
    output logic                     BUSY
);

    localparam int unsigned SPW    = 64 / SAMPLE_WIDTH;
    localparam int unsigned LANE_W = $clog2(SPW);
    localparam int unsigned FREE_W = FIFO_DEPTH_LOG2 + 1;

    state_e                     state_q, state_d;
    logic [TIMESTAMP_WIDTH-1:0] ts_q, ts_d;
    logic [63:0]                acc_q, acc_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [15:0]                wcnt_q, wcnt_d;
    logic                       ovf_q, ovf_d;
    logic                       maxlen_q, maxlen_d;
    logic                       partial_q, partial_d;
    logic [2:0]                 pad_q, pad_d;
    logic [15:0]                drop_q, drop_d;
    logic                       armed_q, armed_d;
    logic                       busy_q, busy_d;

    logic                       hit_c;
    logic                       end_c;
    logic                       word_full_c;
    logic                       word_drop_c;
    logic                       maxlen_hit_c;
    logic                       wr_en_c;
    fifo_word_t                 wr_word_c;
    fifo_word_t                 rd_word;
    logic [FREE_W-1:0]          fifo_free;
    ftr_flags_t                 flags_c;

    // Trigger and end-of-frame detection
`ifdef HIT_FRAME_HYSTERESIS_EN
    localparam int unsigned EXT_W = SAMPLE_WIDTH + 2;
    logic signed [EXT_W-1:0]        low_ext;
    logic        [SAMPLE_WIDTH-1:0] low_lvl;

    always_comb begin
        hit_c   = DIN_VALID && ($signed(DIN) >= $signed(THRESHOLD));
        low_ext = EXT_W'($signed(THRESHOLD)) - $signed({2'b00, HYST});
        if (low_ext < $signed({{3{1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}})) begin
            low_lvl = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        end else begin
            low_lvl = low_ext[SAMPLE_WIDTH-1:0];
        end
        end_c = DIN_VALID && ($signed(DIN) < $signed(low_lvl));
    end
`else
    always_comb begin
        hit_c = DIN_VALID && ($signed(DIN) >= $signed(THRESHOLD));
        end_c = DIN_VALID && !hit_c;
    end
`endif

    // Next-state, packer and FIFO write generation
    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q + TIMESTAMP_WIDTH'(1);
        acc_d        = acc_q;
        lane_d       = lane_q;
        wcnt_d       = wcnt_q;
        ovf_d        = ovf_q;
        maxlen_d     = maxlen_q;
        partial_d    = partial_q;
        pad_d        = pad_q;
        drop_d       = drop_q;
        armed_d      = armed_q;
        word_full_c  = 1'b0;
        word_drop_c  = 1'b0;
        maxlen_hit_c = 1'b0;
        wr_en_c      = 1'b0;
        wr_word_c    = '0;
        flags_c      = '0;

        if (DIN_VALID && !hit_c) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hit_c && armed_q) begin
                    armed_d = 1'b0;
                    if (fifo_free >= FREE_W'(4)) begin
                        wr_en_c        = 1'b1;
                        wr_word_c.data = make_header(CH_ID, 24'(ts_q));
                        acc_d          = '0;
                        lane_d         = '0;
                        wcnt_d         = '0;
                        ovf_d          = 1'b0;
                        maxlen_d       = 1'b0;
                        partial_d      = 1'b0;
                        pad_d          = '0;
                        state_d        = ST_BODY;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            ST_BODY: begin
                if (DELAYED_VALID) begin
                    for (int unsigned i = 0; i < SPW; i++) begin
                        if (lane_q == LANE_W'(i)) begin
                            acc_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = DELAYED_DIN;
                        end
                    end
                    if (lane_q == LANE_W'(SPW - 1)) begin
                        word_full_c = 1'b1;
                        lane_d      = '0;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
                // Keep room for a possible partial word plus the footer
                if (word_full_c) begin
                    if (fifo_free >= FREE_W'(3)) begin
                        wr_en_c        = 1'b1;
                        wr_word_c.data = acc_d;
                        wcnt_d         = sat_inc16(wcnt_q);
                    end else begin
                        word_drop_c = 1'b1;
                        ovf_d       = 1'b1;
                    end
                    acc_d = '0;
                end
                maxlen_hit_c = (MAX_LEN != '0) && (wcnt_d == 16'(MAX_LEN));
                if (word_drop_c) begin
                    state_d = ST_FOOTER;
                end else if (end_c || maxlen_hit_c) begin
                    if (maxlen_hit_c) begin
                        maxlen_d = 1'b1;
                    end
                    state_d = (lane_d != '0) ? ST_FLUSH : ST_FOOTER;
                end
            end
            ST_FLUSH: begin
                wr_en_c        = 1'b1;
                wr_word_c.data = acc_q;
                wcnt_d         = sat_inc16(wcnt_q);
                partial_d      = 1'b1;
                pad_d          = 3'(SPW - 32'(lane_q));
                acc_d          = '0;
                lane_d         = '0;
                state_d        = ST_FOOTER;
            end
            ST_FOOTER: begin
                flags_c.ovf     = ovf_q;
                flags_c.maxlen  = maxlen_q;
                flags_c.partial = partial_q;
                flags_c.empty   = (wcnt_q == 16'd0);
                wr_en_c         = 1'b1;
                wr_word_c.last  = 1'b1;
                wr_word_c.data  = make_footer(CH_ID, wcnt_q, flags_c, pad_q);
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            ts_q      <= '0;
            acc_q     <= '0;
            lane_q    <= '0;
            wcnt_q    <= '0;
            ovf_q     <= 1'b0;
            maxlen_q  <= 1'b0;
            partial_q <= 1'b0;
            pad_q     <= '0;
            drop_q    <= '0;
            armed_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            acc_q     <= acc_d;
            lane_q    <= lane_d;
            wcnt_q    <= wcnt_d;
            ovf_q     <= ovf_d;
            maxlen_q  <= maxlen_d;
            partial_q <= partial_d;
            pad_q     <= pad_d;
            drop_q    <= drop_d;
            armed_q   <= armed_d;
            busy_q    <= busy_d;
        end
    end

    frame_word_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RESETN),
        .wr_en    (wr_en_c),
        .wr_data  (wr_word_c),
        .rd_ready (M_TREADY),
        .rd_data  (rd_word),
        .rd_valid (M_TVALID),
        .free     (fifo_free)
    );

    // Output mapping
    always_comb begin
        M_TDATA  = rd_word.data;
        M_TLAST  = rd_word.last;
        DROP_CNT = drop_q;
        BUSY     = busy_q;
    end

endmodule

// File: tb/tb_hit_frame_gen.sv
// Directed bench for hit_frame_gen (SAMPLE_WIDTH=16, depth 32, channel 8'h3C).
module tb_hit_frame_gen;

    logic        clk;
    logic        rstn;
    logic [15:0] th;
    logic [7:0]  ch;
    logic [7:0]  max_len;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] ddin;
    logic        dvalid;
    logic        tready;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [15:0] drop_cnt;
    logic        busy;
`ifdef HIT_FRAME_HYSTERESIS_EN
    logic [15:0] hyst;
`endif

    int          checks;
    int          errors;
    logic [64:0] q [$];
    logic [23:0] tb_ts;

    hit_frame_gen #(
        .SAMPLE_WIDTH    (16),
        .TIMESTAMP_WIDTH (24),
        .MAX_LEN_WIDTH   (8),
        .FIFO_DEPTH_LOG2 (5)
    ) dut (
        .CLK           (clk),
        .RESETN        (rstn),
        .THRESHOLD     (th),
        .CH_ID         (ch),
        .MAX_LEN       (max_len),
        .DIN           (din),
        .DIN_VALID     (din_valid),
        .DELAYED_DIN   (ddin),
        .DELAYED_VALID (dvalid),
        .M_TDATA       (m_tdata),
        .M_TVALID      (m_tvalid),
        .M_TREADY      (tready),
        .M_TLAST       (m_tlast),
        .DROP_CNT      (drop_cnt),
`ifdef HIT_FRAME_HYSTERESIS_EN
        .HYST          (hyst),
`endif
        .BUSY          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected timestamp: cycles since reset release
    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_ts <= '0;
        else       tb_ts <= tb_ts + 24'd1;
    end

    // Collect transferred words mid-cycle
    always @(negedge clk) begin
        if (rstn === 1'b1 && m_tvalid === 1'b1 && tready === 1'b1)
            q.push_back({m_tlast, m_tdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; th = 16'd100; ch = 8'h3C; max_len = 8'd0; din = 16'd0; din_valid = 1'b0;
        ddin = 16'd0; dvalid = 1'b0; tready = 1'b1;
        repeat (3) tick();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", m_tlast); end
        checks++; if (m_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata got %h exp 0", m_tdata); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %h exp 0", drop_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rstn = 1'b1;
        repeat (2) tick();
    endtask

    // 10 hit samples, then end: two full words plus a two-lane partial
    task automatic test_basic();
        logic [64:0] exp [5];
        logic [64:0] got;
        logic [23:0] ts0;
        q.delete(); th = 16'd100; max_len = 8'd0; tready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            din = (c < 10) ? 16'd120 : 16'd50; din_valid = 1'b1;
            ddin = 16'h1000 + 16'(c); dvalid = 1'b1;
            if (c == 0) ts0 = tb_ts;
            tick();
            if (c == 0) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== {8'hAA, 8'h3C, ts0, 24'h0}) begin
                    errors++;
                    $display("FAIL basic_hdr_latency got v=%b %h exp v=1 %h", m_tvalid, m_tdata, {8'hAA, 8'h3C, ts0, 24'h0});
                end
            end
        end
        exp[0] = {1'b0, 8'hAA, 8'h3C, ts0, 24'h0};
        exp[1] = {1'b0, 64'h1004_1003_1002_1001};
        exp[2] = {1'b0, 64'h1008_1007_1006_1005};
        exp[3] = {1'b0, 64'h0000_0000_100A_1009};
        exp[4] = {1'b1, 64'h553C_0003_2400_0000};
        for (int i = 0; i < 5; i++) begin
            if (i < q.size()) got = q[i]; else got = 65'bx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL basic_word%0d got %h exp %h", i, got, exp[i]); end
        end
        checks++; if (q.size() != 5) begin errors++; $display("FAIL basic_count got %0d exp 5", q.size()); end
    endtask

    // MAX_LEN=2 with a held hit: one frame only, then a fresh hit re-triggers
    task automatic test_max_len();
        logic [64:0] exp [6];
        logic [64:0] got;
        logic [23:0] ts0;
        logic [23:0] ts1;
        q.delete(); max_len = 8'd2; tready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            din = 16'd120; din_valid = 1'b1; ddin = 16'h2000 + 16'(c); dvalid = 1'b1;
            if (c == 0) ts0 = tb_ts;
            tick();
        end
        din = 16'd50;
        repeat (5) tick();
        checks++; if (q.size() != 4) begin errors++; $display("FAIL maxlen_count got %0d exp 4", q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL maxlen_busy got %b exp 0", busy); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL maxlen_drop got %h exp 0", drop_cnt); end
        ts1 = tb_ts; din = 16'd120; dvalid = 1'b0;
        tick();
        din = 16'd50;
        repeat (5) tick();
        exp[0] = {1'b0, 8'hAA, 8'h3C, ts0, 24'h0};
        exp[1] = {1'b0, 64'h2004_2003_2002_2001};
        exp[2] = {1'b0, 64'h2008_2007_2006_2005};
        exp[3] = {1'b1, 64'h553C_0002_4000_0000};
        exp[4] = {1'b0, 8'hAA, 8'h3C, ts1, 24'h0};
        exp[5] = {1'b1, 64'h553C_0000_1000_0000};
        for (int i = 0; i < 6; i++) begin
            if (i < q.size()) got = q[i]; else got = 65'bx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL maxlen_word%0d got %h exp %h", i, got, exp[i]); end
        end
        max_len = 8'd0;
    endtask

    // Stalled output: body stops at 29 words, OVF footer, then a refused trigger
    task automatic test_overflow();
        logic [64:0] hdr;
        logic [64:0] got;
        int          nlast;
        q.delete(); tready = 1'b0;
        for (int c = 0; c < 200; c++) begin
            din = 16'd120; din_valid = 1'b1; ddin = 16'h3000 + 16'(c); dvalid = 1'b1;
            if (c == 0) hdr = {1'b0, 8'hAA, 8'h3C, tb_ts, 24'h0};
            tick();
            if (c == 10) begin
                checks++;
                if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== hdr) begin
                    errors++; $display("FAIL ovf_stall_hold got v=%b %h exp v=1 %h", m_tvalid, {m_tlast, m_tdata}, hdr);
                end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %b exp 0", busy); end
        din = 16'd50; repeat (2) tick();
        din = 16'd120; tick();
        din = 16'd50; repeat (2) tick();
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d exp 1", drop_cnt); end
        checks++; if ({m_tlast, m_tdata} !== hdr) begin errors++; $display("FAIL ovf_head got %h exp %h", {m_tlast, m_tdata}, hdr); end
        tready = 1'b1;
        repeat (40) tick();
        checks++; if (q.size() != 31) begin errors++; $display("FAIL ovf_count got %0d exp 31", q.size()); end
        if (q.size() > 0) got = q[0]; else got = 65'bx;
        checks++; if (got !== hdr) begin errors++; $display("FAIL ovf_word0 got %h exp %h", got, hdr); end
        if (q.size() > 1) got = q[1]; else got = 65'bx;
        checks++; if (got !== {1'b0, 64'h3004_3003_3002_3001}) begin errors++; $display("FAIL ovf_word1 got %h exp %h", got, {1'b0, 64'h3004_3003_3002_3001}); end
        if (q.size() > 30) got = q[30]; else got = 65'bx;
        checks++; if (got !== {1'b1, 64'h553C_001D_8000_0000}) begin errors++; $display("FAIL ovf_footer got %h exp %h", got, {1'b1, 64'h553C_001D_8000_0000}); end
        nlast = 0;
        foreach (q[i]) if (q[i][64]) nlast++;
        checks++; if (nlast != 1) begin errors++; $display("FAIL ovf_tlast_count got %0d exp 1", nlast); end
    endtask

    // Negative threshold: -5 triggers, -6 does not; no delayed samples -> EMPTY
    task automatic test_threshold();
        logic [64:0] hdr;
        logic [64:0] got;
        q.delete(); th = 16'hFFFB; dvalid = 1'b0;
        din = 16'hFFFA; din_valid = 1'b1;
        repeat (5) tick();
        din = 16'hFFFB; din_valid = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL thr_below got busy=%b words=%0d exp 0 0", busy, q.size()); end
        din_valid = 1'b1; hdr = {1'b0, 8'hAA, 8'h3C, tb_ts, 24'h0};
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL thr_equal_busy got %b exp 1", busy); end
        din = 16'hFFFA;
        repeat (5) tick();
        if (q.size() > 0) got = q[0]; else got = 65'bx;
        checks++; if (got !== hdr) begin errors++; $display("FAIL thr_hdr got %h exp %h", got, hdr); end
        if (q.size() > 1) got = q[1]; else got = 65'bx;
        checks++; if (got !== {1'b1, 64'h553C_0000_1000_0000}) begin errors++; $display("FAIL thr_empty_footer got %h exp %h", got, {1'b1, 64'h553C_0000_1000_0000}); end
        checks++; if (q.size() != 2) begin errors++; $display("FAIL thr_count got %0d exp 2", q.size()); end
    endtask

    // Asynchronous reset in the middle of a body with toggling ready
    task automatic test_reset_mid();
        logic [64:0] hdr;
        logic [64:0] got;
        q.delete(); th = 16'd100;
        for (int c = 0; c < 6; c++) begin
            din = 16'd120; din_valid = 1'b1; ddin = 16'h5000 + 16'(c); dvalid = 1'b1;
            tready = (c % 2 == 0);
            tick();
        end
        #2 rstn = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got v=%b l=%b exp 0 0", m_tvalid, m_tlast); end
        checks++; if (m_tdata !== 64'd0) begin errors++; $display("FAIL rmid_tdata got %h exp 0", m_tdata); end
        checks++; if (busy !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rmid_state got busy=%b drop=%0d exp 0 0", busy, drop_cnt); end
        tick(); tick();
        rstn = 1'b1; tready = 1'b1; din = 16'd50; dvalid = 1'b0;
        q.delete();
        repeat (2) tick();
        hdr = {1'b0, 8'hAA, 8'h3C, tb_ts, 24'h0}; din = 16'd120;
        tick();
        din = 16'd50;
        repeat (5) tick();
        if (q.size() > 0) got = q[0]; else got = 65'bx;
        checks++; if (got !== hdr) begin errors++; $display("FAIL rmid_hdr got %h exp %h", got, hdr); end
        if (q.size() > 1) got = q[1]; else got = 65'bx;
        checks++; if (got !== {1'b1, 64'h553C_0000_1000_0000}) begin errors++; $display("FAIL rmid_footer got %h exp %h", got, {1'b1, 64'h553C_0000_1000_0000}); end
    endtask

`ifdef HIT_FRAME_HYSTERESIS_EN
    // TH=100, HYST=10: 95 and 92 keep the frame open, 89 ends it
    task automatic test_hysteresis();
        logic [15:0] seq [8];
        logic [64:0] exp [3];
        logic [64:0] got;
        seq[0] = 16'd120; seq[1] = 16'd95; seq[2] = 16'd92; seq[3] = 16'd89;
        seq[4] = 16'd50;  seq[5] = 16'd50; seq[6] = 16'd50; seq[7] = 16'd50;
        q.delete(); th = 16'd100; hyst = 16'd10; tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            din = seq[c]; din_valid = 1'b1; ddin = 16'h6000 + 16'(c); dvalid = 1'b1;
            if (c == 0) exp[0] = {1'b0, 8'hAA, 8'h3C, tb_ts, 24'h0};
            tick();
        end
        exp[1] = {1'b0, 64'h0000_6003_6002_6001};
        exp[2] = {1'b1, 64'h553C_0001_2200_0000};
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) got = q[i]; else got = 65'bx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL hyst_word%0d got %h exp %h", i, got, exp[i]); end
        end
        hyst = 16'd0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
`ifdef HIT_FRAME_HYSTERESIS_EN
        hyst = 16'd0;
`endif
        test_reset();
        test_basic();
        test_max_len();
        test_overflow();
        test_threshold();
        test_reset_mid();
`ifdef HIT_FRAME_HYSTERESIS_EN
        test_hysteresis();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
